// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared types and constants for the 8-way round-robin arbiter
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_prio_enc8.sv
// rtl/rr_arbiter8_prio_enc8.sv - fixed-priority 8-to-3 encoder, bit 7 highest
module prio_enc8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Ascending scan so the highest set bit is the last assignment and wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_vec[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |in_vec;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter with hold timeout, one idle bubble between grants
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;
  logic [IDX_W-1:0] winner;
  logic             release_now;

  // Rotate so req[ptr] sits on bit 7; the encoder then searches ptr, ptr-1, ... with wrap.
  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      rot[j] = req[ptr_q + IDX_W'(j) + 3'd1];
    end
  end

  prio_enc8 u_prio_enc8 (
    .in_vec (rot),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  assign winner      = ptr_q + 3'd1 + enc_idx;
  assign release_now = done || !req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d         = ST_BUSY;
          gnt_d           = '0;
          gnt_d[winner]   = 1'b1;
          gnt_idx_d       = winner;
          gnt_valid_d     = 1'b1;
          hold_cnt_d      = '0;
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          // Timeout is flagged only when neither done nor withdrawal caused the release.
          timeout_d   = !done && req[gnt_idx_q];
          ptr_d       = gnt_idx_q - 3'd1;
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - scoreboard bench for rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: owner / pointer / hold count as plain integers.
  bit m_busy = 0;
  int m_owner = 0;
  int m_ptr = 7;
  int m_hold = 0;
  bit m_to = 0;
  logic [12:0] exp_q[$];

  always @(posedge clk) begin
    m_to = 0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 7; m_hold = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr - k + 8) % 8;
        if (!m_busy && req[c]) begin
          m_busy = 1; m_owner = c; m_hold = 0;
        end
      end
    end else begin
      if (done || !req[m_owner] || m_hold == MAXH - 1) begin
        m_to = !done && req[m_owner];
        m_ptr = (m_owner + 7) % 8;
        m_busy = 0;
      end else if (m_hold < MAXH - 1) begin
        m_hold++;
      end
    end
    exp_q.push_back({m_busy ? (8'h01 << m_owner) : 8'h00,
                     m_busy ? 3'(m_owner) : 3'd0, m_busy, m_to});
  end

  // Monitor: one registered output set per cycle, sampled at the falling edge.
  bit prev_to = 0;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("outputs", {19'd0, gnt, gnt_idx, gnt_valid, timeout}, {19'd0, e});
      end
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("gnt_at_idx", 32'(gnt[gnt_idx]), 32'(gnt_valid));
      check("timeout_twice", 32'(prev_to && timeout), 32'd0);
      prev_to = timeout;
    end
  end

  task automatic wait_grant(input int exp_idx, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (gnt_valid) found = 1;
    end
    check({name, "_seen"}, 32'(found), 32'd1);
    if (found) check({name, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
  endtask

  task automatic serve(input int exp_idx, input string name);
    wait_grant(exp_idx, name);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check({name, "_bubble"}, 32'(gnt_valid), 32'd0);
  endtask

  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    rst = 1'b1; req = r; done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int hold_len;
    // Reset and fairness across all eight requesters
    do_reset(8'hFF);
    @(negedge clk);
    check("first_gnt", 32'(gnt), 32'h80);
    check("first_idx", 32'(gnt_idx), 32'd7);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int k = 6; k >= 0; k--) serve(k, "fair");
    serve(7, "fair_wrap");

    // Sparse rotation
    do_reset(8'h05);
    serve(2, "sparse0");
    serve(0, "sparse1");
    serve(2, "sparse2");
    serve(0, "sparse3");

    // Timeout after MAX_HOLD cycles
    do_reset(8'h10);
    wait_grant(4, "to_grant");
    hold_len = 1;
    for (int i = 0; i < 20 && gnt_valid; i++) begin
      @(negedge clk);
      if (gnt_valid) hold_len++;
    end
    check("to_len", 32'(hold_len), 32'(MAXH));
    check("to_pulse", 32'(timeout), 32'd1);
    @(negedge clk);
    check("to_regrant", {29'd0, gnt_valid, gnt_idx}, {29'd0, 1'b1, 3'd4});

    // Withdrawal moves the pointer to idx-1; done while idle is ignored
    do_reset(8'h08);
    wait_grant(3, "wd_grant");
    req = 8'h00;
    @(negedge clk);
    check("wd_drop", 32'(gnt), 32'd0);
    req = 8'h0F;
    serve(2, "wd_ptr");
    req = 8'h00;
    @(negedge clk);
    done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_done", 32'(gnt_valid), 32'd0);
    end
    done = 1'b0;

    // Reset mid-grant restores ptr to 7
    do_reset(8'h20);
    wait_grant(5, "mid");
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    rst = 1'b0; req = 8'h21;
    wait_grant(5, "mid_after");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (req ^ 8'(1 << $urandom_range(0, 7)));
      done = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource between 8 requesters.
- Selects one requester at a time and holds the grant until release, forced timeout, or request withdrawal.
- Rotates priority so the last winner becomes lowest priority.
- Sits in front of the shared datapath; its one-hot grant and 3-bit index drive the datapath's select and enable.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 in this revision.
- IDX_W, 3, width of the grant index.
- MAX_HOLD, 16, maximum consecutive cycles a single grant is held (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit k = requester k wants the resource.
- done  input  1  the current owner releases the resource; ignored when no grant is active.
- gnt  output  8  one-hot grant; all zeros when idle.
- gnt_idx  output  3  binary index of the granted requester; 3'b000 when idle.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse: the grant was forcibly released by MAX_HOLD.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - gnt = 8'h00, gnt_idx = 3'b000, gnt_valid = 0, timeout = 0.
  - State = IDLE, ptr = 3'd7, hold_cnt = 0.
  - rst has priority over every other event, including mid-grant: the grant drops on the next edge and no pointer update occurs.
- Priority rule:
  - ptr names the highest-priority index.
  - Search order is descending with wrap: ptr, ptr-1, ..., 0, 7, ..., ptr+1.
  - After reset (ptr = 7) this equals fixed priority with req[7] highest.
- State IDLE:
  - If req != 0 at a rising edge: go to BUSY and load gnt/gnt_idx with the winner; gnt_valid = 1, hold_cnt = 0.
  - Latency: request sampled at edge t, grant visible after edge t+1 (1 cycle).
  - If req == 0: stay in IDLE, outputs stay zero.
- State BUSY: release at an edge when any of the following holds, with priority:
  - (a) done == 1;
  - (b) req[gnt_idx] == 0 (requester withdrew);
  - (c) hold_cnt == MAX_HOLD-1, which additionally sets timeout = 1 for exactly the next cycle.
- On release:
  - Next state = IDLE; gnt = 0, gnt_valid = 0, gnt_idx = 0.
  - ptr = (released index - 1) mod 8, wrapping 0 -> 7.
  - There is a mandatory one-cycle idle bubble between consecutive grants; re-arbitration happens from IDLE on the following edge.
- Otherwise in BUSY: hold_cnt increments by 1 and saturates at MAX_HOLD-1. gnt is stable and other requests are ignored.
- Simultaneous events:
  - done together with timeout condition: release counts as (a), so timeout = 0.
  - done together with req[gnt_idx] low: normal release, single ptr update.
  - New requests arriving during BUSY are not lost; they are considered at the first IDLE edge after release.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[gnt_idx] == gnt_valid.
  - timeout is never high in two consecutive cycles.

Decomposition:
- Shared package/header holds:
  - state encodings: ST_IDLE = 1'b0, ST_BUSY = 1'b1;
  - constants N_REQ = 8, IDX_W = 3;
  - PTR_RST = 3'd7.
- Sub-module prio_enc8: combinational fixed-priority 8-to-3 encoder with bit 7 highest, plus a valid output (any bit set).
- Top-level use of prio_enc8:
  - rotate req so that req[ptr] lands on bit 7, i.e. rot[j] = req[(ptr+1+j) mod 8];
  - encode rot to j;
  - winner = (ptr+1+j) mod 8.
- The FSM, hold counter and pointer register live in rr_arbiter8.

Test Plan:
- Reset: assert rst for 2 cycles with req = 8'hFF -> gnt = 8'h00, gnt_valid = 0, timeout = 0. Release rst -> one cycle later gnt = 8'h80, gnt_idx = 3'd7.
- Fairness: req = 8'hFF held, done pulsed for one cycle each time gnt_valid = 1 -> grant order 7,6,5,4,3,2,1,0,7, each grant separated by exactly one idle cycle.
- Rotation with sparse requests: after reset, req = 8'b00000101 held, done pulsed per grant -> grants 2, 0, 2, 0; ptr after each release is 1, 7, 1, 7.
- Timeout: MAX_HOLD = 4, req = 8'h10 held, done = 0 -> gnt = 8'h10 for exactly 4 cycles, timeout = 1 in the first cycle gnt = 0, and the grant is reissued to index 4 after the idle cycle.
- Withdrawal and done ignored: gnt_idx = 3 active, drop req[3] -> gnt = 0 next cycle and ptr = 2. Pulsing done while IDLE with req = 0 -> no output change.
- Reset mid-operation: rst asserted while gnt = 8'h20 -> all outputs zero next cycle. Then req = 8'h21 -> first grant is index 5, because ptr is back at 7.
